imm_extend_pipe: RTL and testbench

Parametrised, registered immediate-extension unit for the lab CPU datapath. It is the successor to the combinational 16-to-32 sign extender. It takes an IN_WIDTH immediate and a 2-bit mode, and produces an OUT_WIDTH value in one of four modes: sign, zero, upper (LUI) or branch-offset. It uses a valid/ready handshake and a one-entry skid buffer, so it can sit between the decode stage and the execute stage without stalling throughput.

---
 rtl/imm_extend_pipe_pkg.sv | 25 ++
 rtl/imm_extend_pipe_if.sv | 30 +++
 rtl/imm_extend_core.sv | 35 +++
 rtl/imm_extend_pipe.sv | 80 ++++++++
 tb/tb_imm_extend_pipe.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Mode encoding and default widths shared by the immediate-extension datapath
// and the CPU control unit.
package imm_extend_pipe_pkg;

   localparam int unsigned DEF_IN_WIDTH  = 16;
   localparam int unsigned DEF_OUT_WIDTH = 32;
   localparam int unsigned DEF_BR_SHIFT  = 2;
   localparam int unsigned DEF_TAG_WIDTH = 5;
   localparam int unsigned DEF_CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      EXT_SIGN   = 2'b00,
      EXT_ZERO   = 2'b01,
      EXT_UPPER  = 2'b10,
      EXT_BRANCH = 2'b11
   } ext_mode_e;

   // The branch result must hold the whole shifted immediate.
   function automatic bit ext_widths_ok(input int unsigned in_w,
                                        input int unsigned out_w,
                                        input int unsigned br_shift);
      return out_w >= in_w + br_shift;
   endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready stream between decode (master) and the extension unit (slave),
// carrying the raw immediate in and the extended result out.
interface imm_extend_pipe_if #(
   parameter int unsigned IN_WIDTH  = imm_extend_pipe_pkg::DEF_IN_WIDTH,
   parameter int unsigned OUT_WIDTH = imm_extend_pipe_pkg::DEF_OUT_WIDTH,
   parameter int unsigned TAG_WIDTH = imm_extend_pipe_pkg::DEF_TAG_WIDTH
);
   import imm_extend_pipe_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_imm;
   ext_mode_e            in_mode;
   logic [TAG_WIDTH-1:0] in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic [TAG_WIDTH-1:0] out_tag;

   modport master (
      output in_valid, in_imm, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_imm, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );

endinterface

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: sign, zero, upper (LUI) and branch-offset
// forms of an IN_WIDTH immediate at OUT_WIDTH.
module imm_extend_core #(
   parameter int unsigned IN_WIDTH  = imm_extend_pipe_pkg::DEF_IN_WIDTH,
   parameter int unsigned OUT_WIDTH = imm_extend_pipe_pkg::DEF_OUT_WIDTH,
   parameter int unsigned BR_SHIFT  = imm_extend_pipe_pkg::DEF_BR_SHIFT
) (
   input  logic [IN_WIDTH-1:0]           imm,
   input  imm_extend_pipe_pkg::ext_mode_e mode,
   output logic [OUT_WIDTH-1:0]          ext
);
   import imm_extend_pipe_pkg::*;

   localparam int unsigned EXT_BITS = OUT_WIDTH - IN_WIDTH;

   if (!ext_widths_ok(IN_WIDTH, OUT_WIDTH, BR_SHIFT)) begin : g_bad_widths
      $error("imm_extend_core: OUT_WIDTH must be at least IN_WIDTH + BR_SHIFT");
   end

   logic [OUT_WIDTH-1:0] sext_c;
   logic [OUT_WIDTH-1:0] zext_c;

   always_comb begin
      sext_c = OUT_WIDTH'($signed(imm));
      zext_c = OUT_WIDTH'(imm);
      ext    = sext_c;
      case (mode)
         EXT_SIGN:  ext = sext_c;
         EXT_ZERO:  ext = zext_c;
         EXT_UPPER: ext = zext_c << EXT_BITS;
         default:   ext = sext_c << BR_SHIFT;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage: valid/ready handshake with a one-entry
// skid buffer so in_ready never depends combinationally on out_ready.
module imm_extend_pipe #(
   parameter int unsigned IN_WIDTH  = imm_extend_pipe_pkg::DEF_IN_WIDTH,
   parameter int unsigned OUT_WIDTH = imm_extend_pipe_pkg::DEF_OUT_WIDTH,
   parameter int unsigned BR_SHIFT  = imm_extend_pipe_pkg::DEF_BR_SHIFT,
   parameter int unsigned TAG_WIDTH = imm_extend_pipe_pkg::DEF_TAG_WIDTH,
   parameter int unsigned CNT_WIDTH = imm_extend_pipe_pkg::DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   imm_extend_pipe_if.slave     bus,
   output logic [CNT_WIDTH-1:0] xfer_count
);
   import imm_extend_pipe_pkg::*;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic                 skid_valid;
   logic [OUT_WIDTH-1:0] skid_data;
   logic [TAG_WIDTH-1:0] skid_tag;
   logic [OUT_WIDTH-1:0] ext_c;
   logic                 accept_c;
   logic                 xfer_c;

   imm_extend_core #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .BR_SHIFT  (BR_SHIFT)
   ) u_core (
      .imm  (bus.in_imm),
      .mode (bus.in_mode),
      .ext  (ext_c)
   );

   assign bus.in_ready = !skid_valid && !reset;
   assign accept_c     = bus.in_valid && bus.in_ready;
   assign xfer_c       = bus.out_valid && bus.out_ready;

   // Output/skid data path; a full skid implies a full output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_tag   <= '0;
         skid_valid    <= 1'b0;
         skid_data     <= '0;
         skid_tag      <= '0;
      end else if (skid_valid) begin
         if (bus.out_ready) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= skid_data;
            bus.out_tag   <= skid_tag;
            skid_valid    <= 1'b0;
         end
      end else if (accept_c) begin
         if (!bus.out_valid || bus.out_ready) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= ext_c;
            bus.out_tag   <= bus.in_tag;
         end else begin
            skid_valid <= 1'b1;
            skid_data  <= ext_c;
            skid_tag   <= bus.in_tag;
         end
      end else if (xfer_c) begin
         bus.out_valid <= 1'b0;
      end
   end

   // Saturating count of completed output transfers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xfer_count <= '0;
      end else if (xfer_c && (xfer_count != CNT_MAX)) begin
         xfer_count <= xfer_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: default 16->32 instance plus an 8->16 instance
// with a 2-bit counter, checked against an arithmetic queue model.
module tb_imm_extend_pipe;
   import imm_extend_pipe_pkg::*;

   typedef struct {
      logic [63:0] data;
      logic [63:0] tag;
   } item_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   imm_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32), .TAG_WIDTH(5)) bus_a ();
   imm_extend_pipe_if #(.IN_WIDTH(8),  .OUT_WIDTH(16), .TAG_WIDTH(5)) bus_b ();
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   imm_extend_pipe #(
      .IN_WIDTH(16), .OUT_WIDTH(32), .BR_SHIFT(2), .TAG_WIDTH(5), .CNT_WIDTH(16)
   ) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .xfer_count(cnt_a)
   );

   imm_extend_pipe #(
      .IN_WIDTH(8), .OUT_WIDTH(16), .BR_SHIFT(2), .TAG_WIDTH(5), .CNT_WIDTH(2)
   ) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .xfer_count(cnt_b)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Extension from the arithmetic meaning of each mode, reduced mod 2^out_w.
   function automatic logic [63:0] ext_model(input int in_w, input int out_w, input int br,
                                             input logic [63:0] imm, input ext_mode_e mode);
      longint      sval;
      longint      res;
      logic [63:0] mask;
      mask = (64'd1 << out_w) - 64'd1;
      sval = imm[in_w-1] ? (longint'(imm) - (longint'(1) << in_w)) : longint'(imm);
      case (mode)
         EXT_SIGN:  res = sval;
         EXT_ZERO:  res = longint'(imm);
         EXT_UPPER: res = longint'(imm) * (longint'(1) << (out_w - in_w));
         default:   res = sval * (longint'(1) << br);
      endcase
      return 64'(res) & mask;
   endfunction

   item_t       q_a[$];
   item_t       q_b[$];
   int unsigned xf_a = 0;
   int unsigned xf_b = 0;
   logic        stall_a = 1'b0;
   logic        stall_b = 1'b0;
   logic [31:0] hold_d_a;
   logic [4:0]  hold_t_a;
   logic [15:0] hold_d_b;
   logic [4:0]  hold_t_b;

   // Compare process for the default instance.
   always @(negedge clk) begin
      bit    acc;
      item_t it;
      if (reset) begin
         check("a_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
         check("a_rst_in_ready",  64'(bus_a.in_ready),  64'd0);
         check("a_rst_out_data",  64'(bus_a.out_data),  64'd0);
         check("a_rst_out_tag",   64'(bus_a.out_tag),   64'd0);
         check("a_rst_count",     64'(cnt_a),           64'd0);
         q_a.delete();
         xf_a    = 0;
         stall_a = 1'b0;
      end else begin
         check("a_out_valid", 64'(bus_a.out_valid), 64'(q_a.size() > 0));
         check("a_in_ready",  64'(bus_a.in_ready),  64'(q_a.size() < 2));
         check("a_count",     64'(cnt_a), 64'(xf_a > 65535 ? 65535 : xf_a));
         if (q_a.size() > 0) begin
            check("a_out_data", 64'(bus_a.out_data), q_a[0].data);
            check("a_out_tag",  64'(bus_a.out_tag),  q_a[0].tag);
         end
         if (stall_a && bus_a.out_valid) begin
            check("a_stall_data", 64'(bus_a.out_data), 64'(hold_d_a));
            check("a_stall_tag",  64'(bus_a.out_tag),  64'(hold_t_a));
         end
         stall_a  = bus_a.out_valid && !bus_a.out_ready;
         hold_d_a = bus_a.out_data;
         hold_t_a = bus_a.out_tag;
         acc = bus_a.in_valid && (q_a.size() < 2);
         if ((q_a.size() > 0) && bus_a.out_ready) begin
            void'(q_a.pop_front());
            xf_a++;
         end
         if (acc) begin
            it.data = ext_model(16, 32, 2, 64'(bus_a.in_imm), bus_a.in_mode);
            it.tag  = 64'(bus_a.in_tag);
            q_a.push_back(it);
         end
      end
   end

   // Compare process for the narrow instance.
   always @(negedge clk) begin
      bit    acc;
      item_t it;
      if (reset) begin
         check("b_rst_out_valid", 64'(bus_b.out_valid), 64'd0);
         check("b_rst_in_ready",  64'(bus_b.in_ready),  64'd0);
         check("b_rst_count",     64'(cnt_b),           64'd0);
         q_b.delete();
         xf_b    = 0;
         stall_b = 1'b0;
      end else begin
         check("b_out_valid", 64'(bus_b.out_valid), 64'(q_b.size() > 0));
         check("b_in_ready",  64'(bus_b.in_ready),  64'(q_b.size() < 2));
         check("b_count",     64'(cnt_b), 64'(xf_b > 3 ? 3 : xf_b));
         if (q_b.size() > 0) begin
            check("b_out_data", 64'(bus_b.out_data), q_b[0].data);
            check("b_out_tag",  64'(bus_b.out_tag),  q_b[0].tag);
         end
         if (stall_b && bus_b.out_valid) begin
            check("b_stall_data", 64'(bus_b.out_data), 64'(hold_d_b));
            check("b_stall_tag",  64'(bus_b.out_tag),  64'(hold_t_b));
         end
         stall_b  = bus_b.out_valid && !bus_b.out_ready;
         hold_d_b = bus_b.out_data;
         hold_t_b = bus_b.out_tag;
         acc = bus_b.in_valid && (q_b.size() < 2);
         if ((q_b.size() > 0) && bus_b.out_ready) begin
            void'(q_b.pop_front());
            xf_b++;
         end
         if (acc) begin
            it.data = ext_model(8, 16, 2, 64'(bus_b.in_imm), bus_b.in_mode);
            it.tag  = 64'(bus_b.in_tag);
            q_b.push_back(it);
         end
      end
   end

   task automatic send_a(input logic [15:0] imm, input ext_mode_e mode, input logic [4:0] tag,
                         output int tries);
      tries = 0;
      bus_a.in_valid = 1'b1;
      bus_a.in_imm   = imm;
      bus_a.in_mode  = mode;
      bus_a.in_tag   = tag;
      do begin
         @(negedge clk);
         tries++;
      end while (!bus_a.in_ready && tries < 50);
      if (!bus_a.in_ready) check("a_send_timeout", 64'(bus_a.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus_a.in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] imm, input ext_mode_e mode, input logic [4:0] tag);
      int tries = 0;
      bus_b.in_valid = 1'b1;
      bus_b.in_imm   = imm;
      bus_b.in_mode  = mode;
      bus_b.in_tag   = tag;
      do begin
         @(negedge clk);
         tries++;
      end while (!bus_b.in_ready && tries < 50);
      if (!bus_b.in_ready) check("b_send_timeout", 64'(bus_b.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus_b.in_valid = 1'b0;
   endtask

   task automatic expect_a(input string name, input logic [31:0] data, input logic [4:0] tag);
      check({name, "_valid"}, 64'(bus_a.out_valid), 64'd1);
      check({name, "_data"},  64'(bus_a.out_data),  64'(data));
      check({name, "_tag"},   64'(bus_a.out_tag),   64'(tag));
   endtask

   task automatic expect_b(input string name, input logic [15:0] data, input logic [4:0] tag);
      check({name, "_valid"}, 64'(bus_b.out_valid), 64'd1);
      check({name, "_data"},  64'(bus_b.out_data),  64'(data));
      check({name, "_tag"},   64'(bus_b.out_tag),   64'(tag));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] stream_imm [8] = '{16'h8001, 16'h7FFF, 16'h0F0F, 16'hC000,
                                   16'h1234, 16'hFFFE, 16'h00FF, 16'h4000};

   initial begin
      int t;
      int tries3;
      int tsum;
      int c0;
      bus_a.in_valid = 1'b0; bus_a.in_imm = '0; bus_a.in_mode = EXT_SIGN;
      bus_a.in_tag = '0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_imm = '0; bus_b.in_mode = EXT_SIGN;
      bus_b.in_tag = '0; bus_b.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      bus_a.out_ready = 1'b1;
      bus_b.out_ready = 1'b1;

      // Each mode, one cycle after accept, with out_ready held high.
      send_a(16'h9999, EXT_SIGN, 5'd1, t);   expect_a("sign_neg",   32'hFFFF9999, 5'd1);
      send_a(16'h2AAA, EXT_SIGN, 5'd2, t);   expect_a("sign_pos",   32'h00002AAA, 5'd2);
      send_a(16'h9999, EXT_ZERO, 5'd3, t);   expect_a("zero",       32'h00009999, 5'd3);
      send_a(16'h2AAA, EXT_UPPER, 5'd4, t);  expect_a("upper",      32'h2AAA0000, 5'd4);
      send_a(16'hFFFF, EXT_BRANCH, 5'd5, t); expect_a("branch_neg", 32'hFFFFFFFC, 5'd5);
      send_a(16'h0004, EXT_BRANCH, 5'd6, t); expect_a("branch_pos", 32'h00000010, 5'd6);
      tick();
      check("count_after_modes", 64'(cnt_a), 64'd6);

      // Backpressure: two items fill output+skid, the third waits.
      bus_a.out_ready = 1'b0;
      fork
         begin
            send_a(16'h0001, EXT_ZERO, 5'd1, t);
            send_a(16'h0002, EXT_ZERO, 5'd2, t);
            send_a(16'h0003, EXT_ZERO, 5'd3, tries3);
         end
         begin
            repeat (4) tick();
            check("bp_in_ready_low", 64'(bus_a.in_ready), 64'd0);
            expect_a("bp_hold", 32'h00000001, 5'd1);
            bus_a.out_ready = 1'b1;
            tick();
            expect_a("bp_second", 32'h00000002, 5'd2);
            tick();
            expect_a("bp_third", 32'h00000003, 5'd3);
         end
      join
      check("bp_item3_waited", 64'(tries3 > 1), 64'd1);
      tick();
      check("bp_count", 64'(cnt_a), 64'd9);

      // Streaming: one accept per cycle, no stalls.
      c0   = cyc;
      tsum = 0;
      for (int k = 0; k < 8; k++) begin
         send_a(stream_imm[k], ext_mode_e'(2'(k)), 5'(k + 8), t);
         tsum += t;
      end
      check("stream_no_stall", 64'(tsum), 64'd8);
      check("stream_cycles",   64'(cyc - c0), 64'd8);
      tick();
      check("stream_count", 64'(cnt_a), 64'd17);

      // Reset between edges with both registers full.
      bus_a.out_ready = 1'b0;
      send_a(16'h0AAA, EXT_SIGN, 5'd20, t);
      send_a(16'h0BBB, EXT_SIGN, 5'd21, t);
      check("pre_rst_in_ready", 64'(bus_a.in_ready), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
      check("async_rst_in_ready",  64'(bus_a.in_ready),  64'd0);
      check("async_rst_count",     64'(cnt_a),           64'd0);
      tick();
      reset = 1'b0;
      bus_a.out_ready = 1'b1;
      send_a(16'h1234, EXT_SIGN, 5'd7, t);
      expect_a("post_rst", 32'h00001234, 5'd7);
      tick();
      check("post_rst_count", 64'(cnt_a), 64'd1);

      // Narrow instance: extension forms and counter saturation.
      send_b(8'h80, EXT_SIGN, 5'd1);   expect_b("b_sign",   16'hFF80, 5'd1);
      send_b(8'h12, EXT_UPPER, 5'd2);  expect_b("b_upper",  16'h1200, 5'd2);
      send_b(8'h81, EXT_BRANCH, 5'd3); expect_b("b_branch", 16'hFE04, 5'd3);
      send_b(8'hF0, EXT_ZERO, 5'd4);   expect_b("b_zero",   16'h00F0, 5'd4);
      send_b(8'h01, EXT_SIGN, 5'd5);
      tick();
      check("b_count_saturated", 64'(cnt_b), 64'd3);

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench still running at %0t, expected to finish earlier", $time);
      $fatal(1);
   end

endmodule
